// File: rtl/keypad_scan_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scan_fifo_pkg
// Description : Shared debounce state encoding and key-code width helper.
// Revision    : 1.0
// ============================================================================
package keypad_scan_fifo_pkg;

    typedef enum logic [1:0] {
        ST_RELEASED = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_REPEAT   = 2'd3
    } deb_state_e;

    // One extra bit leaves room for the KEY_NONE code (ROWS*COLS).
    function automatic int key_width(input int n_keys);
        return $clog2(n_keys) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_scan_fifo_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scan_fifo_sync_fifo
// Description : Show-ahead synchronous FIFO with registered head and drop-on-full.
// Revision    : 1.0
// ============================================================================
module keypad_scan_fifo_sync_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic             overflow
);

    localparam int              AW       = $clog2(DEPTH);
    localparam logic [AW:0]     FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]     ONE_CNT  = (AW + 1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d, w_rd_next;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             w_pop, w_push;

    assign empty    = (count_q == '0);
    assign full     = (count_q == FULL_CNT);
    assign w_pop    = pop && !empty;
    assign w_push   = push && (!full || w_pop);
    assign overflow = push && full && !w_pop;
    assign dout     = dout_q;
    assign w_rd_next = rd_q + AW'(1);

    always_comb begin
        rd_d    = w_pop  ? w_rd_next     : rd_q;
        wr_d    = w_push ? wr_q + AW'(1) : wr_q;
        count_d = count_q;
        unique case ({w_push, w_pop})
            2'b10:   count_d = count_q + ONE_CNT;
            2'b01:   count_d = count_q - ONE_CNT;
            default: count_d = count_q;
        endcase
        // Head register follows the next entry so key_code is stable and keeps its last value when empty.
        dout_d = dout_q;
        if (w_pop) begin
            if (count_q > ONE_CNT) begin
                dout_d = mem_q[w_rd_next];
            end else if (w_push) begin
                dout_d = din;
            end
        end else if (empty && w_push) begin
            dout_d = din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            dout_q  <= '0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
            dout_q  <= dout_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_q] <= din;
        end
    end

endmodule
`default_nettype wire

// File: rtl/keypad_scan_fifo.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scan_fifo
// Description : Matrix keypad scanner with frame debounce, auto-repeat and event FIFO.
// Revision    : 1.0
// ============================================================================
module keypad_scan_fifo
    import keypad_scan_fifo_pkg::*;
#(
    parameter int  ROWS           = 4,
    parameter int  COLS           = 4,
    parameter int  SCAN_DIV       = 50000,
    parameter int  DEBOUNCE_SCANS = 4,
    parameter int  FIFO_DEPTH     = 4,
    parameter int  REPEAT_EN      = 1,
    parameter int  REPEAT_DELAY   = 50,
    parameter int  REPEAT_RATE    = 10,
    localparam int KW             = key_width(ROWS * COLS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [COLS-1:0] columna,
    output logic [ROWS-1:0] fila,
    output logic [KW-1:0]   key_code,
    output logic            key_valid,
    input  logic            key_ready,
    output logic            key_pressed,
    output logic            fifo_full,
    output logic            overflow
);

    localparam int RW       = $clog2(ROWS);
    localparam int DW       = $clog2(SCAN_DIV);
    localparam int CW       = $clog2(DEBOUNCE_SCANS + 1);
    localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int HW       = $clog2(HOLD_MAX + 1);

    localparam logic [KW-1:0] KEY_NONE   = KW'(ROWS * COLS);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
    localparam logic [CW-1:0] DEB_LIM    = CW'(DEBOUNCE_SCANS);
    localparam logic [HW-1:0] DELAY_LIM  = HW'(REPEAT_DELAY);
    localparam logic [HW-1:0] RATE_LIM   = HW'(REPEAT_RATE);

    logic [1:0][COLS-1:0] sync_q, sync_d;
    logic [DW-1:0]        dwell_q, dwell_d;
    logic [RW-1:0]        row_q, row_d;
    logic [ROWS-1:0]      fila_q, fila_d;
    logic [KW-1:0]        acc_q, acc_d, result_q, result_d;
    logic                 frame_done_q, frame_done_d;

    deb_state_e           state_q, state_d;
    logic [KW-1:0]        cand_q, cand_d, stable_q, stable_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [HW-1:0]        hold_q, hold_d;
    logic                 pressed_q, pressed_d;

    logic                 w_row_hit;
    logic [KW-1:0]        w_row_code, w_sample;
    logic                 w_accept, w_push, w_pop, w_empty;
    logic [KW-1:0]        w_accept_code, w_push_code;
    logic [CW-1:0]        w_cnt_inc;
    logic [HW-1:0]        w_hold_inc, w_hold_lim;

    assign fila        = fila_q;
    assign key_pressed = pressed_q;
    assign key_valid   = !w_empty;
    assign w_pop       = key_valid && key_ready;

    // Synchroniser, row scanning and per-frame lowest-code accumulation.
    always_comb begin
        sync_d[0] = columna;
        sync_d[1] = sync_q[0];

        w_row_hit  = 1'b0;
        w_row_code = KEY_NONE;
        for (int c = COLS - 1; c >= 0; c--) begin
            if (!sync_q[1][c]) begin
                w_row_hit  = 1'b1;
                w_row_code = KW'(int'(row_q) * COLS + c);
            end
        end
        w_sample = (acc_q == KEY_NONE && w_row_hit) ? w_row_code : acc_q;

        dwell_d      = dwell_q + DW'(1);
        row_d        = row_q;
        fila_d       = fila_q;
        acc_d        = acc_q;
        result_d     = result_q;
        frame_done_d = 1'b0;
        if (dwell_q == DWELL_LAST) begin
            dwell_d = '0;
            if (row_q == ROW_LAST) begin
                row_d        = '0;
                result_d     = w_sample;
                frame_done_d = 1'b1;
                acc_d        = KEY_NONE;
            end else begin
                row_d = row_q + RW'(1);
                acc_d = w_sample;
            end
            fila_d = ~(ROWS'(1) << row_d);
        end
    end

    // Debounce / repeat decision, taken once per frame on frame_done.
    always_comb begin
        state_d       = state_q;
        cand_d        = cand_q;
        stable_d      = stable_q;
        cnt_d         = cnt_q;
        hold_d        = hold_q;
        pressed_d     = pressed_q;
        w_accept      = 1'b0;
        w_accept_code = cand_q;
        w_push        = 1'b0;
        w_push_code   = stable_q;
        w_cnt_inc     = cnt_q + CW'(1);
        w_hold_inc    = hold_q + HW'(1);
        w_hold_lim    = (state_q == ST_HELD) ? DELAY_LIM : RATE_LIM;

        if (frame_done_q) begin
            unique case (state_q)
                ST_RELEASED: begin
                    if (result_q != KEY_NONE) begin
                        state_d       = ST_DEBOUNCE;
                        cand_d        = result_q;
                        cnt_d         = CW'(1);
                        w_accept      = (DEB_LIM == CW'(1));
                        w_accept_code = result_q;
                    end
                end
                ST_DEBOUNCE: begin
                    if (result_q == cand_q) begin
                        cnt_d    = w_cnt_inc;
                        w_accept = (w_cnt_inc == DEB_LIM);
                    end else if (result_q == KEY_NONE && !pressed_q) begin
                        state_d = ST_RELEASED;
                    end else begin
                        cand_d        = result_q;
                        cnt_d         = CW'(1);
                        w_accept      = (DEB_LIM == CW'(1));
                        w_accept_code = result_q;
                    end
                end
                ST_HELD, ST_REPEAT: begin
                    if (result_q == stable_q) begin
                        if (REPEAT_EN != 0) begin
                            if (w_hold_inc == w_hold_lim) begin
                                w_push  = 1'b1;
                                hold_d  = '0;
                                state_d = ST_REPEAT;
                            end else begin
                                hold_d = w_hold_inc;
                            end
                        end
                    end else begin
                        // A release is debounced like any other change; key_pressed holds meanwhile.
                        state_d       = ST_DEBOUNCE;
                        cand_d        = result_q;
                        cnt_d         = CW'(1);
                        w_accept      = (DEB_LIM == CW'(1));
                        w_accept_code = result_q;
                    end
                end
            endcase

            if (w_accept) begin
                if (w_accept_code == KEY_NONE) begin
                    state_d   = ST_RELEASED;
                    pressed_d = 1'b0;
                end else begin
                    state_d     = ST_HELD;
                    stable_d    = w_accept_code;
                    hold_d      = '0;
                    pressed_d   = 1'b1;
                    w_push      = 1'b1;
                    w_push_code = w_accept_code;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q       <= '1;
            dwell_q      <= '0;
            row_q        <= '0;
            fila_q       <= ~(ROWS'(1));
            acc_q        <= KEY_NONE;
            result_q     <= KEY_NONE;
            frame_done_q <= 1'b0;
            state_q      <= ST_RELEASED;
            cand_q       <= KEY_NONE;
            stable_q     <= KEY_NONE;
            cnt_q        <= '0;
            hold_q       <= '0;
            pressed_q    <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            dwell_q      <= dwell_d;
            row_q        <= row_d;
            fila_q       <= fila_d;
            acc_q        <= acc_d;
            result_q     <= result_d;
            frame_done_q <= frame_done_d;
            state_q      <= state_d;
            cand_q       <= cand_d;
            stable_q     <= stable_d;
            cnt_q        <= cnt_d;
            hold_q       <= hold_d;
            pressed_q    <= pressed_d;
        end
    end

    keypad_scan_fifo_sync_fifo #(
        .WIDTH (KW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (w_push),
        .din      (w_push_code),
        .pop      (w_pop),
        .dout     (key_code),
        .empty    (w_empty),
        .full     (fifo_full),
        .overflow (overflow)
    );

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_scan_fifo
// Description : Directed bench for keypad_scan_fifo, 4x4 keypad, 16-cycle frames.
// Revision    : 1.0
// ============================================================================
module tb_keypad_scan_fifo;

    logic       clk;
    logic       rst;
    logic [3:0] columna;
    logic [3:0] fila;
    logic [4:0] key_code;
    logic       key_valid;
    logic       key_ready;
    logic       key_pressed;
    logic       fifo_full;
    logic       overflow;

    logic [15:0] keys;
    int          checks = 0;
    int          errors = 0;
    int          tcnt   = 0;
    int          ovf_cnt = 0;

    keypad_scan_fifo #(
        .ROWS           (4),
        .COLS           (4),
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (2),
        .FIFO_DEPTH     (4),
        .REPEAT_EN      (1),
        .REPEAT_DELAY   (3),
        .REPEAT_RATE    (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .columna     (columna),
        .fila        (fila),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .key_pressed (key_pressed),
        .fifo_full   (fifo_full),
        .overflow    (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pressed key shorts its column to its row while that row is driven low.
    always_comb begin
        columna = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r * 4 + c] && fila[r] === 1'b0) columna[c] = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (rst) tcnt <= 0;
        else     tcnt <= tcnt + 1;
        if (overflow === 1'b1) ovf_cnt <= ovf_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int target);
        while (tcnt < target) tick();
    endtask

    task automatic align_frame();
        while (tcnt % 16 != 0) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_expect(input string tag, input logic [4:0] exp);
        check({tag, "_valid"}, {31'd0, key_valid}, 32'd1);
        check({tag, "_code"}, {27'd0, key_code}, {27'd0, exp});
        key_ready = 1'b1;
        tick();
        key_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          base;
        int          ovf0;
        int          vcnt;
        logic [4:0]  codes4 [5];
        logic [4:0]  codes5 [5];
        codes4 = '{5'd0, 5'd5, 5'd10, 5'd15, 5'd3};
        codes5 = '{5'd1, 5'd2, 5'd4, 5'd7, 5'd8};

        keys = '0;
        key_ready = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        check("rst_fila",    {28'd0, fila}, 32'hE);
        check("rst_valid",   {31'd0, key_valid}, 32'd0);
        check("rst_code",    {27'd0, key_code}, 32'd0);
        check("rst_pressed", {31'd0, key_pressed}, 32'd0);
        check("rst_full",    {31'd0, fifo_full}, 32'd0);
        check("rst_ovf",     {31'd0, overflow}, 32'd0);
        rst = 1'b0;

        // Row scan sequence and idle FIFO
        wait_until(3);  check("fila_k3",  {28'd0, fila}, 32'hE);
        wait_until(4);  check("fila_k4",  {28'd0, fila}, 32'hD);
        wait_until(8);  check("fila_k8",  {28'd0, fila}, 32'hB);
        wait_until(12); check("fila_k12", {28'd0, fila}, 32'h7);
        wait_until(16); check("fila_k16", {28'd0, fila}, 32'hE);
        vcnt = 0;
        repeat (160) begin
            tick();
            if (key_valid !== 1'b0) vcnt++;
        end
        check("idle_valid_cycles", vcnt, 0);

        // Single-frame press of key 9 is not accepted
        align_frame();
        base = tcnt;
        keys = 16'h0200;
        wait_until(base + 16);
        keys = '0;
        wait_until(base + 40);
        check("one_frame_valid",   {31'd0, key_valid}, 32'd0);
        check("one_frame_pressed", {31'd0, key_pressed}, 32'd0);

        // Key 9 held: acceptance after 2 frames, repeats at +3,+5,+7 frames
        wait_until(base + 48);
        base = tcnt;
        keys = 16'h0200;
        ovf0 = ovf_cnt;
        wait_until(base + 32);
        check("acc_latency_valid", {31'd0, key_valid}, 32'd0);
        wait_until(base + 33);
        check("acc_valid",   {31'd0, key_valid}, 32'd1);
        check("acc_code",    {27'd0, key_code}, 32'd9);
        check("acc_pressed", {31'd0, key_pressed}, 32'd1);
        check("acc_full",    {31'd0, fifo_full}, 32'd0);
        wait_until(base + 144);
        check("rep_not_full", {31'd0, fifo_full}, 32'd0);
        wait_until(base + 145);
        check("rep_full", {31'd0, fifo_full}, 32'd1);
        wait_until(base + 160);
        keys = '0;
        wait_until(base + 192);
        check("release_pressed_hold", {31'd0, key_pressed}, 32'd1);
        wait_until(base + 193);
        check("release_pressed_clr", {31'd0, key_pressed}, 32'd0);
        check("rep_no_overflow", ovf_cnt - ovf0, 0);
        for (int i = 0; i < 4; i++) pop_expect("rep_pop", 5'd9);
        check("rep_drained", {31'd0, key_valid}, 32'd0);

        // Five presses into a 4-deep FIFO with no consumer
        ovf0 = ovf_cnt;
        for (int i = 0; i < 5; i++) begin
            align_frame();
            base = tcnt;
            keys = 16'd1 << codes4[i];
            wait_until(base + 32);
            if (i == 4) check("ovf_pulse", {31'd0, overflow}, 32'd1);
            wait_until(base + 33);
            if (i == 4) check("ovf_end", {31'd0, overflow}, 32'd0);
            if (i == 2) check("fill3_full", {31'd0, fifo_full}, 32'd0);
            if (i == 3) check("fill4_full", {31'd0, fifo_full}, 32'd1);
            keys = '0;
            wait_until(base + 64);
        end
        check("ovf_count", ovf_cnt - ovf0, 1);
        check("ovf_full", {31'd0, fifo_full}, 32'd1);
        for (int i = 0; i < 4; i++) pop_expect("ovf_pop", codes4[i]);
        check("ovf_drained", {31'd0, key_valid}, 32'd0);
        check("empty_holds_code", {27'd0, key_code}, 32'd15);

        // Full FIFO: push and pop in the same cycle
        ovf0 = ovf_cnt;
        for (int i = 0; i < 5; i++) begin
            align_frame();
            base = tcnt;
            keys = 16'd1 << codes5[i];
            wait_until(base + 32);
            if (i == 4) begin
                key_ready = 1'b1;
                #1;
                check("both_ovf", {31'd0, overflow}, 32'd0);
                tick();
                key_ready = 1'b0;
                check("both_full", {31'd0, fifo_full}, 32'd1);
                check("both_head", {27'd0, key_code}, 32'd2);
            end
            keys = '0;
            wait_until(base + 64);
        end
        check("both_no_overflow", ovf_cnt - ovf0, 0);
        for (int i = 1; i < 5; i++) pop_expect("both_pop", codes5[i]);
        check("both_drained", {31'd0, key_valid}, 32'd0);

        // Two keys together yield the lowest code; then reset mid-debounce
        align_frame();
        base = tcnt;
        keys = 16'h2040;
        wait_until(base + 32);
        keys = '0;
        wait_until(base + 33);
        check("multi_valid", {31'd0, key_valid}, 32'd1);
        check("multi_code",  {27'd0, key_code}, 32'd6);
        wait_until(base + 48);
        keys = 16'h0020;
        wait_until(base + 70);
        rst = 1'b1;
        tick();
        tick();
        check("mid_rst_valid",   {31'd0, key_valid}, 32'd0);
        check("mid_rst_pressed", {31'd0, key_pressed}, 32'd0);
        check("mid_rst_fila",    {28'd0, fila}, 32'hE);
        check("mid_rst_code",    {27'd0, key_code}, 32'd0);
        check("mid_rst_full",    {31'd0, fifo_full}, 32'd0);
        rst = 1'b0;
        wait_until(17);
        check("post_rst_first_frame", {31'd0, key_valid}, 32'd0);
        wait_until(33);
        check("post_rst_valid",   {31'd0, key_valid}, 32'd1);
        check("post_rst_code",    {27'd0, key_code}, 32'd5);
        check("post_rst_pressed", {31'd0, key_pressed}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
